bcd_to_b16: RTL and testbench

//  Sequential converter from a 5-digit packed BCD word to a 16-bit unsigned binary value.
//  It is the inverse of the display-side binary-to-BCD path: keypad/switch digits go in, and a

---
 rtl/bcd_to_b16_pkg.sv | 23 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bcd_to_b16.sv | 150 +++++++++++++++
 tb/tb_bcd_to_b16.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_b16_pkg.sv
// rtl/bcd_to_b16_pkg.sv - shared constants, state encoding and digit helper for the BCD-to-binary converter
//
// Purpose: constants and types shared by bcd_to_b16 and its digit-adjust sub-module.
// Ports:   none (package).
package bcd_to_b16_pkg;

    localparam int BCD_NDIG      = 5;
    localparam int BCD_CONV_W    = 17;
    localparam int BCD_OUT_W     = 16;
    localparam int BCD_DIGIT_MAX = 9;
    localparam int BCD_CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } bcd_state_t;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'(BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - per-digit subtract-3 correction for reverse double-dabble
//
// Purpose: q = (d >= 8) ? d - 3 : d, purely combinational.
// Ports:   d - 4-bit digit after the right shift
//          q - corrected digit
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // The adjust only fires for d >= 8, so the 4-bit subtraction never wraps.
    assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_b16.sv
// rtl/bcd_to_b16.sv - sequential 5-digit packed BCD to 16-bit binary converter
//
// Purpose: converts a packed BCD word to unsigned binary using reverse
//          double-dabble (one right shift plus per-digit correction per cycle),
//          with a start/busy/done handshake, invalid-digit flagging and
//          saturation to all ones when the value does not fit in OUT_W bits.
// Ports:   clk      - rising-edge clock
//          reset    - asynchronous, active-high reset
//          start    - conversion request, sampled only while idle
//          bcd_in   - packed digits, MSD in the top nibble
//          busy     - conversion in flight
//          done     - one-cycle pulse; result and flags valid from this cycle
//          bin      - result, held until the next done
//          overflow - value exceeded 2^OUT_W - 1, bin forced to all ones
//          invalid  - some digit > 9, bin forced to all ones
module bcd_to_b16
    import bcd_to_b16_pkg::*;
#(
    parameter int NDIG   = BCD_NDIG,
    parameter int CONV_W = BCD_CONV_W,
    parameter int OUT_W  = BCD_OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  bin,
    output logic              overflow,
    output logic              invalid
);

    localparam int SR_W = 4*NDIG + CONV_W;

    bcd_state_t              state_q, state_d;
    logic [BCD_CNT_W-1:0]    cnt;
    logic [4*NDIG-1:0]       bcd_r;
    logic [CONV_W-1:0]       bin_r;
    logic [SR_W-1:0]         sr_shifted;
    logic [4*NDIG-1:0]       bcd_adj;
    logic                    any_bad;
    logic                    last;
    logic                    do_load, do_shift, do_fin;

    // Combined shift register moved right by one; the LSB of bcd_r falls into bin_r's MSB.
    assign sr_shifted = {bcd_r, bin_r} >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (sr_shifted[CONV_W + 4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            any_bad = any_bad | digit_invalid(bcd_r[4*i +: 4]);
        end
    end

    assign last = (cnt == BCD_CNT_W'(CONV_W - 1));

    // The digit check looks at the captured register rather than bcd_in, which
    // keeps the input bus off the next-state logic. It is evaluated in the first
    // SHIFT cycle, before any shift has disturbed the digits; an invalid word
    // leaves for FIN without shifting, so that path takes two edges.
    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_shift = 1'b0;
        do_fin   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    do_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == '0 && any_bad) begin
                    state_d = ST_FIN;
                end else begin
                    do_shift = 1'b1;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FIN: begin
                do_fin  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bcd_r    <= '0;
            bin_r    <= '0;
            bin      <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (do_load) begin
                bcd_r <= bcd_in;
                bin_r <= '0;
                cnt   <= '0;
            end
            if (do_shift) begin
                bcd_r <= bcd_adj;
                bin_r <= sr_shifted[CONV_W-1:0];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    done    <= 1'b1;
                    invalid <= 1'b0;
                    if (sr_shifted[CONV_W-1:OUT_W] != '0) begin
                        overflow <= 1'b1;
                        bin      <= '1;
                    end else begin
                        overflow <= 1'b0;
                        bin      <= sr_shifted[OUT_W-1:0];
                    end
                end
            end
            if (do_fin) begin
                done     <= 1'b1;
                invalid  <= 1'b1;
                overflow <= 1'b0;
                bin      <= '1;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_to_b16.sv
// tb/tb_bcd_to_b16.sv - self-checking bench for bcd_to_b16 with a decimal reference model
module tb_bcd_to_b16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin;
    logic        overflow;
    logic        invalid;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_b16 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bcd_in   (bcd_in),
        .busy     (busy),
        .done     (done),
        .bin      (bin),
        .overflow (overflow),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal interpretation of the digits, then invalid/saturation rules.
    function automatic void ref_model(input logic [19:0] v, output logic [15:0] eb,
                                      output bit eov, output bit einv);
        int val;
        int d;
        val  = 0;
        einv = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) einv = 1'b1;
            val = val * 10 + d;
        end
        if (einv) begin
            eb  = 16'hFFFF;
            eov = 1'b0;
        end else if (val > 65535) begin
            eb  = 16'hFFFF;
            eov = 1'b1;
        end else begin
            eb  = 16'(val);
            eov = 1'b0;
        end
    endfunction

    // Called #1 after an edge; the next edge samples start.
    task automatic run_conv(input logic [19:0] v, input bit scramble, input string tag);
        logic [15:0] eb;
        bit          eov, einv;
        int          n;
        ref_model(v, eb, eov, einv);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (scramble) bcd_in = 20'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), einv ? 32'd2 : 32'd17);
        chk({tag, " bin"}, 32'(bin), 32'(eb));
        chk({tag, " overflow"}, 32'(overflow), 32'(eov));
        chk({tag, " invalid"}, 32'(invalid), 32'(einv));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    logic [19:0] bounds [5] = '{20'h12345, 20'h00000, 20'h65535, 20'h65536, 20'h99999};

    initial begin
        int          ndone;
        int          first_e;
        int          last_e;
        logic [19:0] v;

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bin", 32'(bin), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (bounds[i]) run_conv(bounds[i], 1'b0, $sformatf("bound_%05h", bounds[i]));
        run_conv(20'h1A345, 1'b0, "invalid_1A345");
        run_conv(20'h00009, 1'b0, "after_invalid");

        // start presented during the done cycle
        run_conv(20'h12345, 1'b0, "b2b_first");
        run_conv(20'h00042, 1'b0, "b2b_second");

        // start held high: one done every 18 cycles
        bcd_in  = 20'h00042;
        start   = 1'b1;
        ndone   = 0;
        first_e = -1;
        last_e  = -1;
        for (int e = 0; e < 54; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_e < 0) first_e = e;
                last_e = e;
            end
        end
        start = 1'b0;
        chk("held done_count", 32'(ndone), 32'd3);
        chk("held first_done", 32'(first_e), 32'd17);
        chk("held span", 32'(last_e - first_e), 32'd36);
        chk("held bin", 32'(bin), 32'h002A);
        drain();

        // reset mid-conversion
        run_conv(20'h12345, 1'b0, "pre_abort");
        bcd_in = 20'h99999;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort bin", 32'(bin), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        chk("abort invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        chk("abort idle", 32'(busy), 32'd0);

        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 5; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
            run_conv(v, 1'b1, $sformatf("rand_%05h", v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
